// File: rtl/ysyx_22050598_cache_refill_if.sv
// Signal bundle between the miss-refill FSM and its surroundings: miss request,
// LRU array, tag/data array victim read and fill, and the AXI-like memory bus.
interface ysyx_22050598_cache_refill_if #(
    parameter int DATA_W = 64,
    parameter int BEATS  = 2,
    parameter int SET_W  = 6,
    parameter int TAG_W  = 22
);
    logic                      miss_valid;
    logic                      miss_ready;
    logic [31:0]               miss_addr;
    logic                      miss_done;

    logic [SET_W-1:0]          lru_set_index;
    logic [1:0]                lru_way_i;
    logic                      lru_wen;
    logic [1:0]                lru_way_o;

    logic                      vic_valid;
    logic                      vic_dirty;
    logic [TAG_W-1:0]          vic_tag;
    logic [BEATS*DATA_W-1:0]   vic_line;

    logic                      mem_arvalid;
    logic                      mem_arready;
    logic [31:0]               mem_araddr;
    logic                      mem_rvalid;
    logic [DATA_W-1:0]         mem_rdata;
    logic                      mem_rlast;
    logic                      mem_awvalid;
    logic                      mem_awready;
    logic [31:0]               mem_awaddr;
    logic                      mem_wvalid;
    logic                      mem_wready;
    logic [DATA_W-1:0]         mem_wdata;
    logic                      mem_wlast;
    logic                      mem_bvalid;

    logic                      fill_wen;
    logic [SET_W-1:0]          fill_set;
    logic [1:0]                fill_way;
    logic [TAG_W-1:0]          fill_tag;
    logic [BEATS*DATA_W-1:0]   fill_line;

    // The refill FSM side.
    modport master (
        input  miss_valid, miss_addr, lru_way_i,
        input  vic_valid, vic_dirty, vic_tag, vic_line,
        input  mem_arready, mem_rvalid, mem_rdata, mem_rlast,
        input  mem_awready, mem_wready, mem_bvalid,
        output miss_ready, miss_done, lru_set_index, lru_wen, lru_way_o,
        output mem_arvalid, mem_araddr, mem_awvalid, mem_awaddr,
        output mem_wvalid, mem_wdata, mem_wlast,
        output fill_wen, fill_set, fill_way, fill_tag, fill_line
    );

    // Cache arrays and memory side.
    modport slave (
        output miss_valid, miss_addr, lru_way_i,
        output vic_valid, vic_dirty, vic_tag, vic_line,
        output mem_arready, mem_rvalid, mem_rdata, mem_rlast,
        output mem_awready, mem_wready, mem_bvalid,
        input  miss_ready, miss_done, lru_set_index, lru_wen, lru_way_o,
        input  mem_arvalid, mem_araddr, mem_awvalid, mem_awaddr,
        input  mem_wvalid, mem_wdata, mem_wlast,
        input  fill_wen, fill_set, fill_way, fill_tag, fill_line
    );
endinterface

// File: rtl/ysyx_22050598_cache_refill.sv
// Miss-handling FSM: picks the LRU victim, writes it back if dirty, burst-reads
// the missing line, fills the arrays and commits the LRU update. One miss at a time.
module ysyx_22050598_cache_refill #(
    parameter int DATA_W = 64,
    parameter int BEATS  = 2,
    parameter int SET_W  = 6,
    parameter int TAG_W  = 22
) (
    input  logic clk,
    input  logic rst,
    ysyx_22050598_cache_refill_if.master bus
);
    localparam int OFF_W  = 32 - TAG_W - SET_W;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [3:0] {
        IDLE, VICTIM, WB_AW, WB_W, WB_B, RD_AR, RD_R, FILL, DONE
    } state_t;

    state_t                          state;
    logic [SET_W-1:0]                set_q;
    logic [TAG_W-1:0]                tag_q;
    logic [TAG_W-1:0]                vtag_q;
    logic [1:0]                      way_q;
    logic [BEATS-1:0][DATA_W-1:0]    vline_q;
    logic [BEATS-1:0][DATA_W-1:0]    line_q;
    logic [BEAT_W-1:0]               beat_q;
    logic [BEAT_W-1:0]               next_beat;
    logic                            arvalid_q;
    logic                            awvalid_q;
    logic                            wvalid_q;
    logic                            wlast_q;
    logic [DATA_W-1:0]               wdata_q;
    logic                            fill_wen_q;
    logic                            lru_wen_q;
    logic                            done_q;
    logic                            unused_offset;

    assign next_beat     = beat_q + 1'b1;
    assign unused_offset = ^bus.miss_addr[OFF_W-1:0];

    // NOTE: state and datapath registers use non-blocking assignments so every
    // register samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        // NOTE: the line buffers are plain registers, not a RAM, so they are
        // reset along with the control state; a stale line can never be filled.
        if (!rst) begin
            state      <= IDLE;
            set_q      <= '0;
            tag_q      <= '0;
            vtag_q     <= '0;
            way_q      <= '0;
            vline_q    <= '0;
            line_q     <= '0;
            beat_q     <= '0;
            arvalid_q  <= 1'b0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            wlast_q    <= 1'b0;
            wdata_q    <= '0;
            fill_wen_q <= 1'b0;
            lru_wen_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.miss_valid) begin
                        set_q <= bus.miss_addr[OFF_W +: SET_W];
                        tag_q <= bus.miss_addr[31 -: TAG_W];
                        state <= VICTIM;
                    end
                end
                VICTIM: begin
                    // LRU way is combinational on lru_set_index, valid this cycle.
                    way_q   <= bus.lru_way_i;
                    vtag_q  <= bus.vic_tag;
                    vline_q <= bus.vic_line;
                    if (bus.vic_valid && bus.vic_dirty) begin
                        awvalid_q <= 1'b1;
                        state     <= WB_AW;
                    end else begin
                        arvalid_q <= 1'b1;
                        state     <= RD_AR;
                    end
                end
                WB_AW: begin
                    if (bus.mem_awready) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b1;
                        beat_q    <= '0;
                        wdata_q   <= vline_q[0];
                        wlast_q   <= (BEATS == 1);
                        state     <= WB_W;
                    end
                end
                WB_W: begin
                    if (bus.mem_wready) begin
                        if (wlast_q) begin
                            wvalid_q <= 1'b0;
                            wlast_q  <= 1'b0;
                            state    <= WB_B;
                        end else begin
                            beat_q  <= next_beat;
                            wdata_q <= vline_q[next_beat];
                            wlast_q <= (next_beat == LAST_BEAT);
                        end
                    end
                end
                WB_B: begin
                    if (bus.mem_bvalid) begin
                        arvalid_q <= 1'b1;
                        state     <= RD_AR;
                    end
                end
                RD_AR: begin
                    if (bus.mem_arready) begin
                        arvalid_q <= 1'b0;
                        beat_q    <= '0;
                        line_q    <= '0;
                        state     <= RD_R;
                    end
                end
                RD_R: begin
                    if (bus.mem_rvalid) begin
                        line_q[beat_q] <= bus.mem_rdata;
                        beat_q         <= next_beat;
                        // An early rlast leaves the remaining beats at zero.
                        if (bus.mem_rlast || beat_q == LAST_BEAT) begin
                            fill_wen_q <= 1'b1;
                            state      <= FILL;
                        end
                    end
                end
                FILL: begin
                    fill_wen_q <= 1'b0;
                    lru_wen_q  <= 1'b1;
                    done_q     <= 1'b1;
                    state      <= DONE;
                end
                DONE: begin
                    lru_wen_q <= 1'b0;
                    done_q    <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.miss_ready    = (state == IDLE);
    assign bus.miss_done     = done_q;
    assign bus.lru_set_index = set_q;
    assign bus.lru_wen       = lru_wen_q;
    assign bus.lru_way_o     = way_q;

    assign bus.mem_arvalid   = arvalid_q;
    assign bus.mem_araddr    = {tag_q, set_q, {OFF_W{1'b0}}};
    assign bus.mem_awvalid   = awvalid_q;
    assign bus.mem_awaddr    = {vtag_q, set_q, {OFF_W{1'b0}}};
    assign bus.mem_wvalid    = wvalid_q;
    assign bus.mem_wdata     = wdata_q;
    assign bus.mem_wlast     = wlast_q;

    assign bus.fill_wen      = fill_wen_q;
    assign bus.fill_set      = set_q;
    assign bus.fill_way      = way_q;
    assign bus.fill_tag      = tag_q;
    assign bus.fill_line     = line_q;
endmodule

// File: tb/tb_ysyx_22050598_cache_refill.sv
// Directed bench for the cache refill FSM: clean miss, dirty writeback,
// backpressure, mid-burst reset, back-to-back misses and early rlast.
module tb_ysyx_22050598_cache_refill;
    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    ysyx_22050598_cache_refill_if #(.DATA_W(64), .BEATS(2), .SET_W(6), .TAG_W(22)) bus ();

    ysyx_22050598_cache_refill #(.DATA_W(64), .BEATS(2), .SET_W(6), .TAG_W(22)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // LRU array model: victim way is a fixed function of the set index.
    assign bus.lru_way_i = bus.lru_set_index[1:0] ^ 2'b10;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [63:0] D0 = 64'h1111_2222_3333_4444;
    localparam logic [63:0] D1 = 64'h5555_6666_7777_8888;
    localparam logic [63:0] W0 = 64'hAAAA_0000_BBBB_0001;
    localparam logic [63:0] W1 = 64'hCCCC_0002_DDDD_0003;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.miss_valid  = 1'b0;
        bus.miss_addr   = '0;
        bus.vic_valid   = 1'b0;
        bus.vic_dirty   = 1'b0;
        bus.vic_tag     = '0;
        bus.vic_line    = '0;
        bus.mem_arready = 1'b0;
        bus.mem_rvalid  = 1'b0;
        bus.mem_rdata   = '0;
        bus.mem_rlast   = 1'b0;
        bus.mem_awready = 1'b0;
        bus.mem_wready  = 1'b0;
        bus.mem_bvalid  = 1'b0;
    endtask

    // Stimulus only: entered right after the DUT reached RD_AR, leaves it in FILL.
    task automatic zero_wait_read(input logic [63:0] d0, input logic [63:0] d1);
        bus.mem_arready = 1'b1;
        step();
        bus.mem_arready = 1'b0;
        bus.mem_rvalid  = 1'b1;
        bus.mem_rdata   = d0;
        bus.mem_rlast   = 1'b0;
        step();
        bus.mem_rdata   = d1;
        bus.mem_rlast   = 1'b1;
        step();
        bus.mem_rvalid  = 1'b0;
        bus.mem_rlast   = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        n_cmp++;
        if ({bus.miss_ready, bus.mem_arvalid, bus.mem_awvalid, bus.mem_wvalid,
             bus.fill_wen, bus.lru_wen, bus.miss_done} !== 7'b100_0000) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b want 1000000", {bus.miss_ready, bus.mem_arvalid,
                     bus.mem_awvalid, bus.mem_wvalid, bus.fill_wen, bus.lru_wen, bus.miss_done});
        end
        n_cmp++;
        if ({bus.lru_set_index, bus.mem_araddr, bus.fill_line} !== '0) begin
            n_bad++;
            $display("FAIL reset_regs: set %h araddr %h line %h want all zero",
                     bus.lru_set_index, bus.mem_araddr, bus.fill_line);
        end
    endtask

    task automatic test_clean_miss();
        bus.miss_valid = 1'b1;
        bus.miss_addr  = 32'h8000_0010;
        step();                                   // cycle 1: VICTIM
        bus.miss_valid = 1'b0;
        n_cmp++;
        if ({bus.miss_ready, bus.lru_set_index} !== {1'b0, 6'd1}) begin
            n_bad++;
            $display("FAIL clean_victim: ready %b set %0d want 0 1", bus.miss_ready, bus.lru_set_index);
        end
        step();                                   // cycle 2: RD_AR
        n_cmp++;
        if ({bus.mem_arvalid, bus.mem_awvalid, bus.mem_araddr} !== {2'b10, 32'h8000_0010}) begin
            n_bad++;
            $display("FAIL clean_ar: arv %b awv %b araddr %h want 1 0 80000010",
                     bus.mem_arvalid, bus.mem_awvalid, bus.mem_araddr);
        end
        bus.mem_arready = 1'b1;
        step();                                   // cycle 3: RD_R
        bus.mem_arready = 1'b0;
        n_cmp++;
        if (bus.mem_arvalid !== 1'b0) begin
            n_bad++;
            $display("FAIL clean_ar_drop: arvalid %b want 0", bus.mem_arvalid);
        end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = D0;
        step();                                   // cycle 4
        bus.mem_rdata  = D1;
        bus.mem_rlast  = 1'b1;
        step();                                   // cycle 5: FILL
        bus.mem_rvalid = 1'b0;
        bus.mem_rlast  = 1'b0;
        n_cmp++;
        if ({bus.fill_wen, bus.fill_set, bus.fill_way, bus.fill_tag, bus.fill_line}
            !== {1'b1, 6'd1, 2'd3, 22'h200000, D1, D0}) begin
            n_bad++;
            $display("FAIL clean_fill: wen %b set %0d way %0d tag %h line %h want 1 1 3 200000 %h%h",
                     bus.fill_wen, bus.fill_set, bus.fill_way, bus.fill_tag, bus.fill_line, D1, D0);
        end
        step();                                   // cycle 6: DONE
        n_cmp++;
        if ({bus.miss_done, bus.lru_wen, bus.lru_way_o, bus.fill_wen} !== 5'b1_1_11_0) begin
            n_bad++;
            $display("FAIL clean_done: done %b lru_wen %b way %0d fill_wen %b want 1 1 3 0",
                     bus.miss_done, bus.lru_wen, bus.lru_way_o, bus.fill_wen);
        end
        step();                                   // cycle 7: IDLE
        n_cmp++;
        if ({bus.miss_ready, bus.miss_done, bus.lru_wen} !== 3'b100) begin
            n_bad++;
            $display("FAIL clean_idle: ready %b done %b lru_wen %b want 1 0 0",
                     bus.miss_ready, bus.miss_done, bus.lru_wen);
        end
    endtask

    task automatic test_dirty_victim();
        bus.miss_valid = 1'b1;
        bus.miss_addr  = 32'h1234_5050;           // set 5, tag 0x48D14
        step();                                   // cycle 1: VICTIM
        bus.miss_valid = 1'b0;
        bus.vic_valid  = 1'b1;
        bus.vic_dirty  = 1'b1;
        bus.vic_tag    = 22'h200000;
        bus.vic_line   = {W1, W0};
        step();                                   // cycle 2: WB_AW
        bus.vic_valid  = 1'b0;
        bus.vic_dirty  = 1'b0;
        n_cmp++;
        if ({bus.mem_awvalid, bus.mem_arvalid, bus.mem_awaddr} !== {2'b10, 32'h8000_0050}) begin
            n_bad++;
            $display("FAIL dirty_aw: awv %b arv %b awaddr %h want 1 0 80000050",
                     bus.mem_awvalid, bus.mem_arvalid, bus.mem_awaddr);
        end
        bus.mem_awready = 1'b1;
        step();                                   // cycle 3: WB_W beat 0
        bus.mem_awready = 1'b0;
        bus.mem_wready  = 1'b1;
        n_cmp++;
        if ({bus.mem_awvalid, bus.mem_wvalid, bus.mem_wlast, bus.mem_wdata} !== {3'b010, W0}) begin
            n_bad++;
            $display("FAIL dirty_w0: awv %b wv %b wlast %b wdata %h want 0 1 0 %h",
                     bus.mem_awvalid, bus.mem_wvalid, bus.mem_wlast, bus.mem_wdata, W0);
        end
        step();                                   // cycle 4: beat 1
        n_cmp++;
        if ({bus.mem_wvalid, bus.mem_wlast, bus.mem_wdata} !== {2'b11, W1}) begin
            n_bad++;
            $display("FAIL dirty_w1: wv %b wlast %b wdata %h want 1 1 %h",
                     bus.mem_wvalid, bus.mem_wlast, bus.mem_wdata, W1);
        end
        step();                                   // cycle 5: WB_B
        bus.mem_wready = 1'b0;
        n_cmp++;
        if ({bus.mem_wvalid, bus.mem_arvalid} !== 2'b00) begin
            n_bad++;
            $display("FAIL dirty_b: wv %b arv %b want 0 0", bus.mem_wvalid, bus.mem_arvalid);
        end
        bus.mem_bvalid = 1'b1;
        step();                                   // cycle 6: RD_AR
        bus.mem_bvalid = 1'b0;
        n_cmp++;
        if ({bus.mem_arvalid, bus.mem_araddr} !== {1'b1, 32'h1234_5050}) begin
            n_bad++;
            $display("FAIL dirty_ar: arv %b araddr %h want 1 12345050", bus.mem_arvalid, bus.mem_araddr);
        end
        zero_wait_read(D0, D1);                   // cycle 9: FILL
        n_cmp++;
        if ({bus.fill_wen, bus.fill_set, bus.fill_way, bus.fill_tag, bus.fill_line}
            !== {1'b1, 6'd5, 2'd3, 22'h048D14, D1, D0}) begin
            n_bad++;
            $display("FAIL dirty_fill: wen %b set %0d way %0d tag %h line %h",
                     bus.fill_wen, bus.fill_set, bus.fill_way, bus.fill_tag, bus.fill_line);
        end
        step();                                   // cycle 10: DONE
        n_cmp++;
        if ({bus.miss_done, bus.lru_wen, bus.lru_way_o} !== 4'b1_1_11) begin
            n_bad++;
            $display("FAIL dirty_done: done %b lru_wen %b way %0d want 1 1 3",
                     bus.miss_done, bus.lru_wen, bus.lru_way_o);
        end
        step();
    endtask

    task automatic test_backpressure();
        bus.miss_valid = 1'b1;
        bus.miss_addr  = 32'h0000_0120;           // set 18, tag 0, way 0
        step();
        bus.miss_valid = 1'b0;
        bus.vic_valid  = 1'b1;
        bus.vic_dirty  = 1'b1;
        bus.vic_tag    = 22'h3FFFFF;
        bus.vic_line   = {W1, W0};
        step();                                   // WB_AW
        bus.vic_valid  = 1'b0;
        bus.vic_dirty  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if ({bus.mem_awvalid, bus.mem_awaddr} !== {1'b1, 32'hFFFF_FD20}) begin
                n_bad++;
                $display("FAIL bp_aw_hold%0d: awv %b awaddr %h want 1 fffffd20",
                         i, bus.mem_awvalid, bus.mem_awaddr);
            end
            step();
        end
        bus.mem_awready = 1'b1;
        step();                                   // WB_W
        bus.mem_awready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if ({bus.mem_wvalid, bus.mem_wlast, bus.mem_wdata} !== {2'b10, W0}) begin
                n_bad++;
                $display("FAIL bp_w_hold%0d: wv %b wlast %b wdata %h want 1 0 %h",
                         i, bus.mem_wvalid, bus.mem_wlast, bus.mem_wdata, W0);
            end
            step();
        end
        bus.mem_wready = 1'b1;
        step();
        n_cmp++;
        if ({bus.mem_wvalid, bus.mem_wlast, bus.mem_wdata} !== {2'b11, W1}) begin
            n_bad++;
            $display("FAIL bp_w1: wv %b wlast %b wdata %h want 1 1 %h",
                     bus.mem_wvalid, bus.mem_wlast, bus.mem_wdata, W1);
        end
        step();                                   // WB_B
        bus.mem_wready = 1'b0;
        bus.mem_bvalid = 1'b1;
        step();                                   // RD_AR
        bus.mem_bvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if ({bus.mem_arvalid, bus.mem_awvalid, bus.mem_araddr} !== {2'b10, 32'h0000_0120}) begin
                n_bad++;
                $display("FAIL bp_ar_hold%0d: arv %b awv %b araddr %h want 1 0 00000120",
                         i, bus.mem_arvalid, bus.mem_awvalid, bus.mem_araddr);
            end
            step();
        end
        bus.mem_arready = 1'b1;
        step();                                   // RD_R
        bus.mem_arready = 1'b0;
        bus.mem_rvalid  = 1'b1;
        bus.mem_rdata   = D1;
        step();
        bus.mem_rvalid  = 1'b0;                   // one-cycle gap between beats
        bus.mem_rdata   = 64'hDEAD_DEAD_DEAD_DEAD;
        step();
        bus.mem_rvalid  = 1'b1;
        bus.mem_rdata   = D0;
        bus.mem_rlast   = 1'b1;
        step();                                   // FILL
        bus.mem_rvalid  = 1'b0;
        bus.mem_rlast   = 1'b0;
        n_cmp++;
        if ({bus.fill_wen, bus.fill_set, bus.fill_way, bus.fill_line} !== {1'b1, 6'd18, 2'd0, D0, D1}) begin
            n_bad++;
            $display("FAIL bp_fill: wen %b set %0d way %0d line %h want 1 18 0 %h%h",
                     bus.fill_wen, bus.fill_set, bus.fill_way, bus.fill_line, D0, D1);
        end
        step();
        step();
    endtask

    task automatic test_reset_mid_burst();
        logic strobe_seen;
        bus.miss_valid = 1'b1;
        bus.miss_addr  = 32'h0000_0030;
        step();                                   // VICTIM
        bus.miss_valid = 1'b0;
        step();                                   // RD_AR
        bus.mem_arready = 1'b1;
        step();                                   // RD_R
        bus.mem_arready = 1'b0;
        bus.mem_rvalid  = 1'b1;
        bus.mem_rdata   = D0;
        step();                                   // beat 0 taken
        rst = 1'b0;
        bus.mem_rdata   = D1;
        bus.mem_rlast   = 1'b1;
        step();                                   // reset edge
        rst = 1'b1;
        bus.mem_rvalid  = 1'b0;
        bus.mem_rlast   = 1'b0;
        n_cmp++;
        if ({bus.miss_ready, bus.fill_wen, bus.lru_wen, bus.fill_line} !== {3'b100, 128'h0}) begin
            n_bad++;
            $display("FAIL rst_burst_idle: ready %b fill_wen %b lru_wen %b line %h want 1 0 0 0",
                     bus.miss_ready, bus.fill_wen, bus.lru_wen, bus.fill_line);
        end
        strobe_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            strobe_seen = strobe_seen | bus.fill_wen | bus.lru_wen | bus.miss_done;
        end
        n_cmp++;
        if (strobe_seen !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_burst_strobe: strobe seen %b want 0", strobe_seen);
        end
    endtask

    task automatic test_back_to_back();
        bus.miss_valid = 1'b1;
        bus.miss_addr  = 32'h0000_1000;           // set 0, tag 4, way 2
        step();                                   // VICTIM
        bus.miss_addr  = 32'hABCD_E3F0;           // set 63, tag 0x2AF378, way 1; held valid
        step();                                   // RD_AR
        zero_wait_read(D0, D1);                   // FILL
        n_cmp++;
        if ({bus.fill_wen, bus.fill_set, bus.fill_way, bus.fill_tag} !== {1'b1, 6'd0, 2'd2, 22'd4}) begin
            n_bad++;
            $display("FAIL b2b_fill0: wen %b set %0d way %0d tag %h want 1 0 2 4",
                     bus.fill_wen, bus.fill_set, bus.fill_way, bus.fill_tag);
        end
        step();                                   // DONE
        n_cmp++;
        if ({bus.miss_done, bus.lru_way_o, bus.miss_ready} !== 4'b1_10_0) begin
            n_bad++;
            $display("FAIL b2b_done0: done %b way %0d ready %b want 1 2 0",
                     bus.miss_done, bus.lru_way_o, bus.miss_ready);
        end
        step();                                   // IDLE, second miss presented
        n_cmp++;
        if (bus.miss_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_ready: ready %b want 1", bus.miss_ready);
        end
        step();                                   // VICTIM for set 63
        bus.miss_valid = 1'b0;
        n_cmp++;
        if (bus.lru_set_index !== 6'd63) begin
            n_bad++;
            $display("FAIL b2b_set1: set %0d want 63", bus.lru_set_index);
        end
        step();                                   // RD_AR
        n_cmp++;
        if (bus.mem_araddr !== 32'hABCD_E3F0) begin
            n_bad++;
            $display("FAIL b2b_ar1: araddr %h want abcde3f0", bus.mem_araddr);
        end
        zero_wait_read(D1, D0);
        n_cmp++;
        if ({bus.fill_wen, bus.fill_set, bus.fill_way, bus.fill_tag, bus.fill_line}
            !== {1'b1, 6'd63, 2'd1, 22'h2AF378, D0, D1}) begin
            n_bad++;
            $display("FAIL b2b_fill1: wen %b set %0d way %0d tag %h line %h",
                     bus.fill_wen, bus.fill_set, bus.fill_way, bus.fill_tag, bus.fill_line);
        end
        step();
        n_cmp++;
        if ({bus.miss_done, bus.lru_wen, bus.lru_way_o} !== 4'b1_1_01) begin
            n_bad++;
            $display("FAIL b2b_done1: done %b lru_wen %b way %0d want 1 1 1",
                     bus.miss_done, bus.lru_wen, bus.lru_way_o);
        end
        step();
    endtask

    task automatic test_early_rlast();
        bus.miss_valid = 1'b1;
        bus.miss_addr  = 32'h0000_0040;           // set 4, way 2
        step();
        bus.miss_valid = 1'b0;
        step();                                   // RD_AR
        bus.mem_arready = 1'b1;
        step();                                   // RD_R
        bus.mem_arready = 1'b0;
        bus.mem_rvalid  = 1'b1;
        bus.mem_rdata   = D0;
        bus.mem_rlast   = 1'b1;
        step();                                   // FILL after a single beat
        bus.mem_rdata   = 64'hFFFF_FFFF_FFFF_FFFF; // stray beats must be ignored
        bus.mem_rlast   = 1'b0;
        n_cmp++;
        if ({bus.fill_wen, bus.fill_set, bus.fill_way, bus.fill_line} !== {1'b1, 6'd4, 2'd2, 64'h0, D0}) begin
            n_bad++;
            $display("FAIL early_fill: wen %b set %0d way %0d line %h want 1 4 2 0%h",
                     bus.fill_wen, bus.fill_set, bus.fill_way, bus.fill_line, D0);
        end
        step();                                   // DONE
        n_cmp++;
        if ({bus.miss_done, bus.fill_line} !== {1'b1, 64'h0, D0}) begin
            n_bad++;
            $display("FAIL early_extra: done %b line %h want 1 0%h", bus.miss_done, bus.fill_line, D0);
        end
        bus.mem_rvalid = 1'b0;
        step();
        n_cmp++;
        if (bus.miss_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL early_idle: ready %b want 1", bus.miss_ready);
        end
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        test_reset();
        test_clean_miss();
        test_dirty_victim();
        test_backpressure();
        test_reset_mid_burst();
        test_back_to_back();
        test_early_rlast();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
